// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU (c_*) and loader/DMA (d_*) request ports, memory side, status.
// slave = arbiter view; master = requesters plus memory view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_enab;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output mem_enab, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  mem_enab, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader-DMA) arbiter for a single unified memory, one word transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of fixed CPU priority.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be in 1..15");
  end

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    lat_q, lat_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          any_req, grant, pick;

  assign any_req = bus.c_req | bus.d_req;
  assign grant   = (state_q == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  assign pick = (bus.c_req && bus.d_req) ? ~last_owner_q : ~bus.c_req;

  always_ff @(posedge clk) begin
    if (reset)      last_owner_q <= 1'b0;
    else if (grant) last_owner_q <= pick;
  end
`else
  assign pick = ~bus.c_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_q     <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lat_q     <= lat_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (lat_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request regs only change on a grant, so they double as the held memory address/data.
  always_comb begin
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_d     = lat_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    if (grant) begin
      win_d   = pick;
      we_d    = pick ? bus.d_we    : bus.c_we;
      addr_d  = pick ? bus.d_addr  : bus.c_addr;
      wdata_d = pick ? bus.d_wdata : bus.c_wdata;
      lat_d   = LAT_INIT;
    end
    if (state_q == ACCESS) begin
      if (lat_q != '0) lat_d = lat_q - 4'd1;
      else if (win_q)  d_rdata_d = bus.mem_rdata;
      else             c_rdata_d = bus.mem_rdata;
    end
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.owner     = win_q;
    bus.c_ack     = (state_q == ACK) && !win_q;
    bus.d_ack     = (state_q == ACK) &&  win_q;
    bus.c_rdata   = c_rdata_q;
    bus.d_rdata   = d_rdata_q;
    bus.mem_enab  = (state_q == ACCESS) && (lat_q == LAT_INIT) && we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a MEM_LAT=1 instance with a memory model, plus a MEM_LAT=3 instance.
module tb_mem_arbiter;
  localparam int unsigned LAT1 = 1;

  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3))    dut3 (.clk(clk), .reset(rst3), .bus(bus3));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned enab_cnt = 0;
  logic [31:0] exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem3_rdata = '0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i == 16) ? 32'hDEADBEEF : (32'h5A5A0000 ^ 32'(i * 257));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model for the LAT=1 instance: combinational read, write on strobe.
  assign bus1.mem_rdata = mem[bus1.mem_addr[7:0]];
  assign bus3.mem_rdata = mem3_rdata;

  always @(posedge clk) begin
    if (rst1) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(32'(i));
    end else if (bus1.mem_enab) begin
      mem[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst1 && (bus1.c_ack || bus1.d_ack)) begin
      if (sb_q.size() == 0) begin
        check("spurious_ack", {30'd0, bus1.c_ack, bus1.d_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", {31'd0, bus1.d_ack}, {31'd0, e.port});
        check("ack_single", {31'd0, bus1.c_ack & bus1.d_ack}, 32'd0);
        check("owner", {31'd0, bus1.owner}, {31'd0, e.port});
        if (e.rd) check("rdata", e.port ? bus1.d_rdata : bus1.c_rdata, e.data);
      end
    end
    if (!rst1 && bus1.mem_enab) begin
      enab_cnt++;
      check("wr_addr", bus1.mem_addr, exp_waddr);
      check("wr_data", bus1.mem_wdata, exp_wdata);
    end
  end

  task automatic drive(input bit p, input bit req, input bit we, input logic [7:0] addr, input logic [31:0] wd);
    if (p) begin
      bus1.d_req = req; bus1.d_we = we; bus1.d_addr = {24'd0, addr}; bus1.d_wdata = wd;
    end else begin
      bus1.c_req = req; bus1.c_we = we; bus1.c_addr = {24'd0, addr}; bus1.c_wdata = wd;
    end
  endtask

  // Entered just after a rising edge with the DUT idle; returns just after the edge following ack.
  task automatic xact(input bit p, input bit we, input logic [7:0] addr, input logic [31:0] wd, input bit pulse);
    int unsigned n;
    bit got;
    n = 0;
    got = 1'b0;
    if (we) begin
      ref_mem[addr] = wd;
      exp_waddr = {24'd0, addr};
      exp_wdata = wd;
    end
    sb_q.push_back('{p, !we, ref_mem[addr]});
    enab_cnt = 0;
    drive(p, 1'b1, we, addr, wd);
    while (!got && n < 20) begin
      @(negedge clk);
      if (p ? bus1.d_ack : bus1.c_ack) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
        if (pulse) drive(p, 1'b0, 1'b0, 8'd0, 32'd0);
      end
    end
    drive(p, 1'b0, 1'b0, 8'd0, 32'd0);
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    else      check("ack_latency", n, 1 + LAT1);
    @(posedge clk); #1;
    check("busy_after_ack", {31'd0, bus1.busy}, 32'd0);
    check("wr_strobes", enab_cnt, we ? 32'd1 : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t, c_t, d_t, acks;
    int unsigned ack_t [3];
    bit cd, dd;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(32'(i));
    drive(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    bus3.c_req = 1'b0; bus3.c_we = 1'b0; bus3.c_addr = '0; bus3.c_wdata = '0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, bus1.busy},     32'd0);
    check("rst_owner", {31'd0, bus1.owner},    32'd0);
    check("rst_cack",  {31'd0, bus1.c_ack},    32'd0);
    check("rst_dack",  {31'd0, bus1.d_ack},    32'd0);
    check("rst_enab",  {31'd0, bus1.mem_enab}, 32'd0);
    check("rst_maddr", bus1.mem_addr,  32'd0);
    check("rst_mwdat", bus1.mem_wdata, 32'd0);
    check("rst_crdat", bus1.c_rdata,   32'd0);
    check("rst_drdat", bus1.d_rdata,   32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk); #1;

    // CPU read of 0x10 with explicit cycle-by-cycle view
    sb_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    drive(1'b0, 1'b1, 1'b0, 8'h10, 32'd0);
    @(negedge clk);
    check("t1_busy_c0", {31'd0, bus1.busy}, 32'd0);
    @(posedge clk); #1;
    check("t1_maddr_c1", bus1.mem_addr, 32'h10);
    check("t1_enab_c1", {31'd0, bus1.mem_enab}, 32'd0);
    check("t1_busy_c1", {31'd0, bus1.busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_cack_c2", {31'd0, bus1.c_ack}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(posedge clk); #1;
    check("t1_busy_c3", {31'd0, bus1.busy}, 32'd0);
    check("t1_cack_c3", {31'd0, bus1.c_ack}, 32'd0);

    xact(1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0);
    xact(1'b0, 1'b0, 8'h20, 32'd0, 1'b0);
    xact(1'b1, 1'b0, 8'h40, 32'd0, 1'b1);
    xact(1'b0, 1'b1, 8'h44, 32'hCAFEF00D, 1'b1);
    xact(1'b0, 1'b0, 8'h44, 32'd0, 1'b0);

    // Simultaneous requests; the previous grant went to the CPU
`ifdef MEM_ARB_ROUND_ROBIN_EN
    sb_q.push_back('{1'b1, 1'b1, ref_mem[8'h30]});
    sb_q.push_back('{1'b0, 1'b1, ref_mem[8'h10]});
`else
    sb_q.push_back('{1'b0, 1'b1, ref_mem[8'h10]});
    sb_q.push_back('{1'b1, 1'b1, ref_mem[8'h30]});
`endif
    drive(1'b0, 1'b1, 1'b0, 8'h10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h30, 32'd0);
    t = 0; c_t = 0; d_t = 0; cd = 1'b0; dd = 1'b0;
    while (!(cd && dd) && t < 30) begin
      @(negedge clk);
      if (bus1.c_ack) begin cd = 1'b1; c_t = t; drive(1'b0, 1'b0, 1'b0, 8'd0, 32'd0); end
      if (bus1.d_ack) begin dd = 1'b1; d_t = t; drive(1'b1, 1'b0, 1'b0, 8'd0, 32'd0); end
      @(posedge clk); #1;
      t++;
    end
    check("both_done", {31'd0, cd && dd}, 32'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("both_d_time", d_t, 1 + LAT1);
    check("both_c_time", c_t, 2 * (LAT1 + 2) - 1);
`else
    check("both_c_time", c_t, 1 + LAT1);
    check("both_d_time", d_t, 2 * (LAT1 + 2) - 1);
`endif

    // CPU read request held high across three transactions
    repeat (3) sb_q.push_back('{1'b0, 1'b1, ref_mem[8'h10]});
    enab_cnt = 0;
    drive(1'b0, 1'b1, 1'b0, 8'h10, 32'd0);
    t = 0; acks = 0;
    while (acks < 3 && t < 40) begin
      @(negedge clk);
      if (bus1.c_ack) begin
        ack_t[acks] = t;
        acks++;
        if (acks == 3) drive(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      end
      @(posedge clk); #1;
      t++;
    end
    check("cont_acks", acks, 32'd3);
    check("cont_gap1", ack_t[1] - ack_t[0], LAT1 + 2);
    check("cont_gap2", ack_t[2] - ack_t[1], LAT1 + 2);
    check("cont_no_wr", enab_cnt, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);

    // MEM_LAT=3 instance: ack 4 cycles after request, data from third ACCESS cycle
    bus3.c_req = 1'b1; bus3.c_addr = 32'h44; mem3_rdata = 32'hBAD0BAD0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      mem3_rdata = (cyc == 3) ? 32'hC0FFEE00 : 32'hBAD0BAD0;
      @(negedge clk);
      check("l3_cack", {31'd0, bus3.c_ack}, (cyc == 4) ? 32'd1 : 32'd0);
      check("l3_enab", {31'd0, bus3.mem_enab}, 32'd0);
      if (cyc == 1) check("l3_maddr", bus3.mem_addr, 32'h44);
      if (cyc == 4) begin
        check("l3_rdata", bus3.c_rdata, 32'hC0FFEE00);
        bus3.c_req = 1'b0;
      end
    end

    // Reset during the second ACCESS cycle of a read
    @(posedge clk); #1;
    bus3.c_req = 1'b1; bus3.c_addr = 32'h48;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1;
    bus3.c_req = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    check("mr_busy",  {31'd0, bus3.busy},     32'd0);
    check("mr_owner", {31'd0, bus3.owner},    32'd0);
    check("mr_cack",  {31'd0, bus3.c_ack},    32'd0);
    check("mr_enab",  {31'd0, bus3.mem_enab}, 32'd0);
    check("mr_maddr", bus3.mem_addr,  32'd0);
    check("mr_mwdat", bus3.mem_wdata, 32'd0);
    check("mr_crdat", bus3.c_rdata,   32'd0);
    check("mr_drdat", bus3.d_rdata,   32'd0);
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus3.c_ack || bus3.d_ack || bus3.busy) acks++;
    end
    check("mr_no_ack", acks, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
